// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-ported fixed-latency memory
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    input  logic        IFlush,
    output logic [31:0] IRData,
    output logic        IValid,
    input  logic        DReq,
    input  logic        DWE,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    input  logic [1:0]  DSize,
    input  logic        DSign,
    output logic [31:0] DRData,
    output logic        DValid,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWE,
    output logic [1:0]  MemSize,
    output logic        MemSign,
    input  logic [31:0] MemRData,
    output logic        StallIF,
    output logic        StallMEM
);

    typedef enum logic [1:0] {ST_IDLE, ST_IBUSY, ST_DBUSY} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       LP_SIZE_WORD = 2'b10;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_d;
    logic             r_flush_pend;
    logic             r_first;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_sign;
    logic [31:0]      r_irdata;
    logic [31:0]      r_drdata;
    logic             r_ivalid;
    logic             r_dvalid;

    logic w_d_elig;
    logic w_i_elig;
    logic w_grant_d;
    logic w_grant_i;
    logic w_busy;
    logic w_done;

    // A side whose valid is high this cycle is completing, so it must not be re-accepted.
    assign w_d_elig  = DReq & ~r_dvalid;
    assign w_i_elig  = IReq & ~r_ivalid & ~IFlush;
    assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last_d);
    assign w_grant_i = w_i_elig & (~w_d_elig |  r_last_d);
    assign w_busy    = (r_state != ST_IDLE);
    assign w_done    = w_busy && (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_next = ST_DBUSY;
                end else if (w_grant_i) begin
                    w_next = ST_IBUSY;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                if (w_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_last_d     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_first      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_sign       <= 1'b0;
            r_irdata     <= '0;
            r_drdata     <= '0;
            r_ivalid     <= 1'b0;
            r_dvalid     <= 1'b0;
        end else begin
            r_ivalid <= 1'b0;
            r_dvalid <= 1'b0;
            r_first  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_grant_d) begin
                    r_addr   <= DAddr;
                    r_wdata  <= DWData;
                    r_we     <= DWE;
                    r_size   <= DSize;
                    r_sign   <= DSign;
                    r_cnt    <= LP_CNT_INIT;
                    r_last_d <= 1'b1;
                    r_first  <= 1'b1;
                end else if (w_grant_i) begin
                    r_addr   <= IAddr;
                    r_wdata  <= '0;
                    r_we     <= 1'b0;
                    r_size   <= LP_SIZE_WORD;
                    r_sign   <= 1'b0;
                    r_cnt    <= LP_CNT_INIT;
                    r_last_d <= 1'b0;
                    r_first  <= 1'b1;
                end
            end else if (w_done) begin
                // A flush seen in the final busy cycle also discards the fetch.
                if (r_state == ST_IBUSY) begin
                    if (!(r_flush_pend | IFlush)) begin
                        r_irdata <= MemRData;
                        r_ivalid <= 1'b1;
                    end
                end else begin
                    r_drdata <= MemRData;
                    r_dvalid <= 1'b1;
                end
                r_flush_pend <= 1'b0;
            end else begin
                r_cnt <= r_cnt - LP_CNT_ONE;
                if ((r_state == ST_IBUSY) && IFlush) begin
                    r_flush_pend <= 1'b1;
                end
            end
        end
    end

    assign MemAddr  = w_busy ? r_addr  : '0;
    assign MemWData = w_busy ? r_wdata : '0;
    assign MemSize  = w_busy ? r_size  : '0;
    assign MemSign  = w_busy & r_sign;
    assign MemWE    = (r_state == ST_DBUSY) & r_we & r_first;

    assign IRData   = r_irdata;
    assign IValid   = r_ivalid;
    assign DRData   = r_drdata;
    assign DValid   = r_dvalid;
    assign StallIF  = IReq & ~r_ivalid;
    assign StallMEM = DReq & ~r_dvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at latency 2 and latency 1
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReq, IFlush, DReq, DWE, DSign;
    logic [31:0] IAddr, DAddr, DWData, MemRData;
    logic [1:0]  DSize;

    logic [31:0] IRData, DRData, MemAddr, MemWData;
    logic        IValid, DValid, MemWE, MemSign, StallIF, StallMEM;
    logic [1:0]  MemSize;

    logic [31:0] IRData_1, DRData_1, MemAddr_1, MemWData_1;
    logic        IValid_1, DValid_1, MemWE_1, MemSign_1, StallIF_1, StallMEM_1;
    logic [1:0]  MemSize_1;

    int n_checks = 0;
    int n_errors = 0;
    int n_ivalid_1 = 0;
    int n_dvalid_1 = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IFlush(IFlush), .IRData(IRData), .IValid(IValid),
        .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWData(DWData), .DSize(DSize), .DSign(DSign),
        .DRData(DRData), .DValid(DValid),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemSize(MemSize),
        .MemSign(MemSign), .MemRData(MemRData),
        .StallIF(StallIF), .StallMEM(StallMEM)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IFlush(IFlush), .IRData(IRData_1), .IValid(IValid_1),
        .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWData(DWData), .DSize(DSize), .DSign(DSign),
        .DRData(DRData_1), .DValid(DValid_1),
        .MemAddr(MemAddr_1), .MemWData(MemWData_1), .MemWE(MemWE_1), .MemSize(MemSize_1),
        .MemSign(MemSign_1), .MemRData(MemRData),
        .StallIF(StallIF_1), .StallMEM(StallMEM_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        IReq = 0; IFlush = 0; IAddr = 0;
        DReq = 0; DWE = 0; DAddr = 0; DWData = 0; DSize = 0; DSign = 0;
        MemRData = 0;
        cyc();
        cyc();
        chk("rst_ivalid", IValid, 0);
        chk("rst_dvalid", DValid, 0);
        chk("rst_irdata", IRData, 0);
        chk("rst_drdata", DRData, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_memwe", MemWE, 0);

        // single fetch
        reset = 1'b0;
        IReq = 1; IAddr = 32'h100; MemRData = 32'hDEADBEEF;
        #1;
        chk("f_stall_idle", StallIF, 1);
        chk("f_addr_idle", MemAddr, 0);
        cyc();
        chk("f_addr_c1", MemAddr, 32'h100);
        chk("f_ivalid_c1", IValid, 0);
        chk("f_stall_c1", StallIF, 1);
        cyc();
        chk("f_addr_c2", MemAddr, 32'h100);
        chk("f_ivalid_c2", IValid, 0);
        cyc();
        chk("f_ivalid", IValid, 1);
        chk("f_irdata", IRData, 32'hDEADBEEF);
        chk("f_addr_done", MemAddr, 0);
        chk("f_stall_done", StallIF, 0);
        IReq = 0;
        cyc();
        chk("f_ivalid_off", IValid, 0);

        // tie after reset: D first, then I in the DValid cycle
        DReq = 1; DWE = 0; DAddr = 32'h200; DSize = 2'b10;
        IReq = 1; IAddr = 32'h104; MemRData = 32'hAAAA0001;
        cyc();
        chk("t_dgrant", MemAddr, 32'h200);
        chk("t_we_load", MemWE, 0);
        cyc();
        cyc();
        chk("t_dvalid", DValid, 1);
        chk("t_drdata", DRData, 32'hAAAA0001);
        chk("t_stallmem", StallMEM, 0);
        chk("t_stallif", StallIF, 1);
        DReq = 0; MemRData = 32'hBBBB0002;
        cyc();
        chk("t_igrant", MemAddr, 32'h104);
        chk("t_dvalid_off", DValid, 0);
        cyc();
        cyc();
        chk("t_ivalid", IValid, 1);
        chk("t_irdata", IRData, 32'hBBBB0002);
        IReq = 0;

        // store, granted in the IValid cycle
        DReq = 1; DWE = 1; DAddr = 32'h40; DWData = 32'h12345678; DSize = 2'b10;
        #1;
        chk("s_stall_req", StallMEM, 1);
        cyc();
        chk("s_we_c1", MemWE, 1);
        chk("s_addr", MemAddr, 32'h40);
        chk("s_wdata", MemWData, 32'h12345678);
        chk("s_size", MemSize, 2'b10);
        cyc();
        chk("s_we_c2", MemWE, 0);
        chk("s_size_c2", MemSize, 2'b10);
        chk("s_stall_c2", StallMEM, 1);
        cyc();
        chk("s_dvalid", DValid, 1);
        chk("s_stall_done", StallMEM, 0);
        chk("s_we_done", MemWE, 0);
        DReq = 0;
        cyc();
        chk("s_idle_addr", MemAddr, 0);

        // true tie with last grant D: I wins
        DReq = 1; DWE = 0; DAddr = 32'h300; DSize = 2'b00;
        IReq = 1; IAddr = 32'h108; MemRData = 32'h11110004;
        cyc();
        chk("rr_igrant", MemAddr, 32'h108);
        cyc();
        cyc();
        chk("rr_ivalid", IValid, 1);
        chk("rr_irdata", IRData, 32'h11110004);
        IReq = 0; MemRData = 32'h22220007;
        cyc();
        chk("rr_dgrant", MemAddr, 32'h300);
        cyc();
        cyc();
        chk("rr_dvalid", DValid, 1);
        chk("rr_drdata", DRData, 32'h22220007);
        DReq = 0;
        cyc();

        // flush in first IBUSY cycle
        IReq = 1; IAddr = 32'h200; MemRData = 32'hCCCC0003;
        cyc();
        chk("fl_grant", MemAddr, 32'h200);
        IFlush = 1;
        cyc();
        IFlush = 0;
        chk("fl_busy", MemAddr, 32'h200);
        cyc();
        chk("fl_no_ivalid", IValid, 0);
        chk("fl_irdata_kept", IRData, 32'h11110004);
        chk("fl_idle", MemAddr, 0);
        chk("fl_stallif", StallIF, 1);
        IAddr = 32'h204; MemRData = 32'hDDDD0005;
        cyc();
        chk("fl_regrant", MemAddr, 32'h204);
        cyc();
        cyc();
        chk("fl_ivalid", IValid, 1);
        chk("fl_irdata", IRData, 32'hDDDD0005);
        IReq = 0;

        // reset in the middle of DBUSY
        DReq = 1; DWE = 0; DAddr = 32'h80; MemRData = 32'hEEEE0006;
        cyc();
        chk("r_grant", MemAddr, 32'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("r_addr_async", MemAddr, 0);
        chk("r_drdata_async", DRData, 0);
        chk("r_irdata_async", IRData, 0);
        chk("r_dvalid_async", DValid, 0);
        chk("r_stallmem", StallMEM, 1);
        cyc();
        chk("r_dvalid_held", DValid, 0);
        reset = 1'b0;
        cyc();
        chk("r_regrant", MemAddr, 32'h80);
        cyc();
        chk("r_dvalid_early", DValid, 0);
        cyc();
        chk("r_dvalid", DValid, 1);
        chk("r_drdata", DRData, 32'hEEEE0006);
        DReq = 0;

        // latency 1: continuous requests alternate D, I
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        IReq = 1; IAddr = 32'h400;
        DReq = 1; DWE = 0; DAddr = 32'h500; DSize = 2'b00;
        MemRData = 32'h5A5A5A5A;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("l1_addr_%0d", k), MemAddr_1,
                (k % 2 == 0) ? 32'h0 : ((k % 4 == 1) ? 32'h500 : 32'h400));
            chk($sformatf("l1_dvalid_%0d", k), DValid_1, (k % 4 == 2) ? 32'h1 : 32'h0);
            chk($sformatf("l1_ivalid_%0d", k), IValid_1, (k % 4 == 0) ? 32'h1 : 32'h0);
            if (DValid_1) n_dvalid_1++;
            if (IValid_1) n_ivalid_1++;
        end
        chk("l1_dvalid_count", n_dvalid_1, 3);
        chk("l1_ivalid_count", n_ivalid_1, 3);
        IReq = 0; DReq = 0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
